div_seq_param: RTL

- Parametrised multi-cycle restoring divider. It is the successor to the fixed 32-bit signed divider in multdiv.
- Adds a WIDTH parameter, a per-operation signed/unsigned mode, a remainder output, a busy flag, restart/abort semantics and an asynchronous reset.
- Sits beside the multiplier in the multdiv unit. The processor's MULT/DIV control drives it and waits on data_resultRDY.

---
 rtl/div_seq_param_if.sv | 26 ++
 rtl/div_seq_param.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/div_seq_param_if.sv
// Handshake and data bundle for the sequential divider in the multdiv unit.
interface div_seq_param_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic             is_signed;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Requester side: MULT/DIV control.
  modport master (
    output ctrl_DIV, is_signed, data_operandA, data_operandB,
    input  result, remainder, data_exception, data_resultRDY, busy
  );

  // Divider side.
  modport slave (
    input  ctrl_DIV, is_signed, data_operandA, data_operandB,
    output result, remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are fixed up at
// writeback: the quotient truncates toward zero and the remainder follows
// the dividend's sign.
module div_seq_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic            clk,
  input logic            reset,
  div_seq_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw dividend, returned on divide-by-zero
  logic [WIDTH-1:0]   dvd_q, dvd_d;      // |A|, shifted out MSB first
  logic [WIDTH-1:0]   bmag_q, bmag_d;    // |B|
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               exc_q, exc_d;

  logic               s_a, s_b;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH-1:0]   quo_step, rem_step;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  // Next-state, datapath step and writeback.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    dvd_d       = dvd_q;
    bmag_d      = bmag_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    s_a         = bus.is_signed & bus.data_operandA[WIDTH-1];
    s_b         = bus.is_signed & bus.data_operandB[WIDTH-1];

    // The full previous remainder is kept in the shift so that unsigned
    // divisors above 2^(WIDTH-1) cannot lose the partial remainder's MSB.
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, bmag_q};
    q_bit    = ~trial[WIDTH+1];
    rem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], q_bit};

    if (bus.ctrl_DIV) begin
      // Start from IDLE/DONE, or abort-and-restart from CALC.
      a_d     = bus.data_operandA;
      dvd_d   = s_a ? negate(bus.data_operandA) : bus.data_operandA;
      bmag_d  = s_b ? negate(bus.data_operandB) : bus.data_operandB;
      neg_q_d = s_a ^ s_b;
      neg_r_d = s_a;
      quo_d   = '0;
      rem_d   = '0;
      cnt_d   = '0;
      state_d = CALC;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DONE: state_d = IDLE;
        CALC: begin
          if (bmag_q == '0) begin
            result_d    = '0;
            remainder_d = a_q;
            exc_d       = 1'b1;
            state_d     = DONE;
          end else begin
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_d    = neg_q_q ? negate(quo_step) : quo_step;
              remainder_d = neg_r_q ? negate(rem_step) : rem_step;
              exc_d       = 1'b0;
              state_d     = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      dvd_q       <= '0;
      bmag_q      <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      dvd_q       <= dvd_d;
      bmag_q      <= bmag_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
    end
  end

  assign bus.result         = result_q;
  assign bus.remainder      = remainder_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == CALC);

endmodule
